// File: rtl/rca_pkg.sv
// Shared constants and helpers for the pipelined ripple-carry adder.
package rca_pkg;

  localparam int DEFAULT_WIDTH = 64;
  localparam int DEFAULT_CHUNK = 4;

  function automatic int calcStages(int width, int chunk);
    return width / chunk;
  endfunction

endpackage

// File: rtl/rca_chunk.sv
// Combinational CHUNK-bit ripple adder; also exposes the carry into its top bit
// so the final slice can derive signed overflow.
module rca_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] sum,
  output logic             cout,
  output logic             c_msb_in
);

  logic [CHUNK:0] w_carry;

  assign w_carry[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_bit
    rca_full_adder u_fa (
      .a   (a[i]),
      .b   (b[i]),
      .cin (w_carry[i]),
      .sum (sum[i]),
      .cout(w_carry[i+1])
    );
  end

  assign cout     = w_carry[CHUNK];
  assign c_msb_in = w_carry[CHUNK-1];

endmodule

// File: rtl/rca_full_adder.sv
// 1-bit full-adder cell, the building block of every ripple chunk.
module rca_full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/rca_pipe_adder.sv
// Pipelined ripple-carry adder/subtractor: one CHUNK-bit slice per stage, carry
// registered between stages, whole pipe advancing on a single enable.
module rca_pipe_adder
  import rca_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int CHUNK = DEFAULT_CHUNK
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int STAGES = calcStages(WIDTH, CHUNK);
  localparam int LAST   = STAGES - 1;

  if ((WIDTH % CHUNK) != 0) begin : g_badWidth
    $error("rca_pipe_adder: WIDTH must be a multiple of CHUNK");
  end

  // r_as holds the unconsumed upper A slices in its low bits and the finished sum
  // slices in its high bits; each stage shifts one A slice out and one sum slice in,
  // so after the last stage it is exactly the sum.
  logic             r_valid [STAGES];
  logic [WIDTH-1:0] r_as    [STAGES];
  logic [WIDTH-1:0] r_b     [STAGES];
  logic             r_carry [STAGES];
  logic             r_ovf   [STAGES];

  logic [WIDTH-1:0] w_aIn   [STAGES];
  logic [WIDTH-1:0] w_bIn   [STAGES];
  logic             w_cIn   [STAGES];
  logic             w_vIn   [STAGES];
  logic [CHUNK-1:0] w_slice [STAGES];
  logic             w_cOut  [STAGES];
  logic             w_cMsb  [STAGES];
  logic             w_advance;

  assign w_advance = !r_valid[LAST] || out_ready;
  assign in_ready  = w_advance && !rst;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    if (k == 0) begin : g_head
      assign w_aIn[k] = a;
      assign w_bIn[k] = sub ? ~b : b;
      assign w_cIn[k] = sub ? 1'b1 : cin;
      assign w_vIn[k] = in_valid;
    end else begin : g_body
      assign w_aIn[k] = r_as[k-1];
      assign w_bIn[k] = r_b[k-1];
      assign w_cIn[k] = r_carry[k-1];
      assign w_vIn[k] = r_valid[k-1];
    end

    rca_chunk #(.CHUNK(CHUNK)) u_chunk (
      .a       (w_aIn[k][CHUNK-1:0]),
      .b       (w_bIn[k][CHUNK-1:0]),
      .cin     (w_cIn[k]),
      .sum     (w_slice[k]),
      .cout    (w_cOut[k]),
      .c_msb_in(w_cMsb[k])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= 1'b0;
        r_as[k]    <= '0;
        r_b[k]     <= '0;
        r_carry[k] <= 1'b0;
        r_ovf[k]   <= 1'b0;
      end
    end else if (w_advance) begin
      for (int k = 0; k < STAGES; k++) begin
        r_valid[k] <= w_vIn[k];
        r_as[k]    <= (w_aIn[k] >> CHUNK) | (WIDTH'(w_slice[k]) << (WIDTH - CHUNK));
        r_b[k]     <= w_bIn[k] >> CHUNK;
        r_carry[k] <= w_cOut[k];
        r_ovf[k]   <= w_cMsb[k] ^ w_cOut[k];
      end
    end
  end

  assign out_valid = r_valid[LAST];
  assign sum       = r_as[LAST];
  assign cout      = r_carry[LAST];
  assign ovf       = r_ovf[LAST];

endmodule

// File: tb/tb_rca_pipe_adder.sv
// Scoreboard bench: drives an 8-bit (2-stage) and a 64-bit (16-stage) instance and
// checks every emitted result against a plain-arithmetic model.
module tb_rca_pipe_adder;

  localparam int HALF = 5;

  typedef struct {
    logic [63:0] sum;
    logic        cout;
    logic        ovf;
    int          stamp;
    bit          timed;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        inValid [2];
  logic        inReady [2];
  logic        inCin   [2];
  logic        inSub   [2];
  logic        outValid[2];
  logic        outReady[2];
  logic        outCout [2];
  logic        outOvf  [2];
  logic [63:0] inA     [2];
  logic [63:0] inB     [2];
  logic [63:0] outSum  [2];
  logic [7:0]  sum8;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  exp_t q8[$];
  exp_t q64[$];
  bit   randReady = 1'b0;
  logic holdReady = 1'b1;
  bit   checkLatency = 1'b1;
  bit          stalled [2];
  logic [63:0] savedSum[2];
  logic        savedCout[2];
  logic        savedOvf[2];
  int   widths[2] = '{8, 64};
  int   stages[2] = '{2, 16};

  always #HALF clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  rca_pipe_adder #(.WIDTH(8), .CHUNK(4)) dut8 (
    .clk(clk), .rst(rst), .in_valid(inValid[0]), .in_ready(inReady[0]),
    .a(inA[0][7:0]), .b(inB[0][7:0]), .cin(inCin[0]), .sub(inSub[0]),
    .out_valid(outValid[0]), .out_ready(outReady[0]), .sum(sum8),
    .cout(outCout[0]), .ovf(outOvf[0])
  );
  assign outSum[0] = {56'd0, sum8};

  rca_pipe_adder dut64 (
    .clk(clk), .rst(rst), .in_valid(inValid[1]), .in_ready(inReady[1]),
    .a(inA[1]), .b(inB[1]), .cin(inCin[1]), .sub(inSub[1]),
    .out_valid(outValid[1]), .out_ready(outReady[1]), .sum(outSum[1]),
    .cout(outCout[1]), .ovf(outOvf[1])
  );

  // Reference: unsigned add/subtract on a wider integer, signed overflow from sign rules.
  function automatic exp_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    exp_t        e;
    logic [63:0] mask;
    logic [63:0] am;
    logic [63:0] bm;
    logic [64:0] full;
    logic        sa;
    logic        sb;
    logic        ss;
    mask = (w == 64) ? '1 : ((64'd1 << w) - 64'd1);
    am = a & mask;
    bm = b & mask;
    if (sub) begin
      full   = {1'b0, am} - {1'b0, bm};
      e.cout = (am >= bm);
    end else begin
      full   = {1'b0, am} + {1'b0, bm} + 65'(cin);
      e.cout = full[w];
    end
    e.sum = full[63:0] & mask;
    sa = am[w-1];
    sb = bm[w-1];
    ss = e.sum[w-1];
    e.ovf   = sub ? ((sa != sb) && (ss != sa)) : ((sa == sb) && (ss != sa));
    e.stamp = 0;
    e.timed = 1'b0;
    return e;
  endfunction

  function automatic logic [63:0] rand64();
    case ($urandom_range(0, 7))
      0:       return '1;
      1:       return 64'd0;
      2:       return 64'h8000_0000_0000_0000;
      3:       return 64'h7FFF_FFFF_FFFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  task automatic checkOutput(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Presents one op and holds it until the DUT accepts it, then records the expectation.
  task automatic applyStimulus(int d, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    exp_t e;
    int   waited;
    bit   done;
    e = model(widths[d], a, b, cin, sub);
    waited = 0;
    done = 1'b0;
    @(negedge clk);
    inValid[d] = 1'b1;
    inA[d] = a;
    inB[d] = b;
    inCin[d] = cin;
    inSub[d] = sub;
    while (!done) begin
      #2;
      if (inReady[d]) begin
        done = 1'b1;
        e.stamp = cyc;
        e.timed = checkLatency;
        if (d == 0) q8.push_back(e);
        else q64.push_back(e);
      end else if (waited > 200) begin
        done = 1'b1;
        checks++;
        errors++;
        $display("[TB] FAIL accept_timeout%0d: got in_ready 0 for %0d cycles expected acceptance", widths[d], waited);
        inValid[d] = 1'b0;
      end else begin
        waited++;
        @(negedge clk);
      end
    end
  endtask

  task automatic idle(int d, int n);
    repeat (n) begin
      @(negedge clk);
      inValid[d] = 1'b0;
    end
  endtask

  task automatic drain(int n);
    int i;
    i = 0;
    while ((q8.size() != 0 || q64.size() != 0) && i < n) begin
      @(negedge clk);
      i++;
    end
    repeat (2) @(negedge clk);
  endtask

  // Monitor: chooses out_ready for the coming edge, then checks handshake, stall
  // stability and any result that transfers on that edge.
  always @(negedge clk) begin
    exp_t e;
    bit   have;
    for (int d = 0; d < 2; d++) outReady[d] = randReady ? 1'($urandom_range(0, 1)) : holdReady;
    #1;
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        stalled[d] = 1'b0;
      end else begin
        checkOutput($sformatf("in_ready%0d", widths[d]), 64'(inReady[d]), 64'(!outValid[d] || outReady[d]));
        if (stalled[d]) begin
          checkOutput($sformatf("stall_valid%0d", widths[d]), 64'(outValid[d]), 64'd1);
          checkOutput($sformatf("stall_sum%0d", widths[d]), outSum[d], savedSum[d]);
          checkOutput($sformatf("stall_cout%0d", widths[d]), 64'(outCout[d]), 64'(savedCout[d]));
          checkOutput($sformatf("stall_ovf%0d", widths[d]), 64'(outOvf[d]), 64'(savedOvf[d]));
        end
        if (outValid[d] && outReady[d]) begin
          have = 1'b0;
          if (d == 0 && q8.size() > 0) begin
            e = q8.pop_front();
            have = 1'b1;
          end else if (d == 1 && q64.size() > 0) begin
            e = q64.pop_front();
            have = 1'b1;
          end
          if (!have) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected%0d: got result %h with empty scoreboard expected no output", widths[d], outSum[d]);
          end else begin
            checkOutput($sformatf("sum%0d", widths[d]), outSum[d], e.sum);
            checkOutput($sformatf("cout%0d", widths[d]), 64'(outCout[d]), 64'(e.cout));
            checkOutput($sformatf("ovf%0d", widths[d]), 64'(outOvf[d]), 64'(e.ovf));
            if (e.timed) checkOutput($sformatf("latency%0d", widths[d]), 64'(cyc - e.stamp), 64'(stages[d]));
          end
        end
        stalled[d]   = outValid[d] && !outReady[d];
        savedSum[d]  = outSum[d];
        savedCout[d] = outCout[d];
        savedOvf[d]  = outOvf[d];
      end
    end
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no finish within time limit expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      inValid[d] = 1'b0;
      inA[d] = '0;
      inB[d] = '0;
      inCin[d] = 1'b0;
      inSub[d] = 1'b0;
      outReady[d] = 1'b1;
      stalled[d] = 1'b0;
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    for (int d = 0; d < 2; d++) begin
      checkOutput($sformatf("rst_in_ready%0d", widths[d]), 64'(inReady[d]), 64'd0);
      checkOutput($sformatf("rst_out_valid%0d", widths[d]), 64'(outValid[d]), 64'd0);
      checkOutput($sformatf("rst_sum%0d", widths[d]), outSum[d], 64'd0);
      checkOutput($sformatf("rst_cout%0d", widths[d]), 64'(outCout[d]), 64'd0);
      checkOutput($sformatf("rst_ovf%0d", widths[d]), 64'(outOvf[d]), 64'd0);
    end
    @(negedge clk);
    rst = 1'b0;

    applyStimulus(0, 64'h3C, 64'h0F, 1'b0, 1'b0);
    applyStimulus(0, 64'hFF, 64'h01, 1'b0, 1'b0);
    applyStimulus(0, 64'h7F, 64'h01, 1'b0, 1'b0);
    applyStimulus(0, 64'h05, 64'h07, 1'b1, 1'b1);
    applyStimulus(0, 64'h80, 64'h80, 1'b0, 1'b0);
    applyStimulus(0, 64'h80, 64'h01, 1'b0, 1'b1);
    idle(0, 1);

    applyStimulus(1, '1, 64'd1, 1'b0, 1'b0);
    applyStimulus(1, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0);
    applyStimulus(1, 64'd0, 64'd1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++)
      applyStimulus(1, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    idle(1, 1);
    drain(200);

    checkLatency = 1'b0;
    randReady = 1'b1;
    fork
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) idle(0, 1);
          applyStimulus(0, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(0, 1);
      end
      begin
        for (int i = 0; i < 150; i++) begin
          if ($urandom_range(0, 3) == 0) idle(1, 1);
          applyStimulus(1, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end
        idle(1, 1);
      end
    join
    randReady = 1'b0;
    holdReady = 1'b1;
    drain(600);
    checkLatency = 1'b1;

    for (int i = 0; i < 10; i++)
      applyStimulus(1, rand64(), rand64(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    @(negedge clk);
    rst = 1'b1;
    inValid[1] = 1'b0;
    q64.delete();
    q8.delete();
    @(negedge clk);
    #1;
    checkOutput("midrst_out_valid", 64'(outValid[1]), 64'd0);
    checkOutput("midrst_sum", outSum[1], 64'd0);
    checkOutput("midrst_cout", 64'(outCout[1]), 64'd0);
    checkOutput("midrst_ovf", 64'(outOvf[1]), 64'd0);
    checkOutput("midrst_in_ready", 64'(inReady[1]), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    idle(1, 20);
    applyStimulus(1, 64'h0000_1234_FFFF_FFFF, 64'h0000_4321_0000_0001, 1'b1, 1'b0);
    idle(1, 1);
    drain(100);

    checkOutput("scoreboard8_empty", 64'(q8.size()), 64'd0);
    checkOutput("scoreboard64_empty", 64'(q64.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
